pipeline_lsu: RTL and testbench
===============================

// Module: pipeline_lsu
// PURPOSE
//   Parametrised load/store unit for the MEM stage of the pipeline processor. Replaces the fixed single-cycle dmem access.
//   Talks to a variable-latency memory over a req/gnt/rvalid handshake, one access outstanding at a time.
//   Handles byte/half/word alignment (big-endian lanes) and load sign/zero extension.
//   Flags misaligned or illegal accesses and exposes busy so the hazard logic can stall IF/ID/EX.
// PARAMETERS
//   DATA_W   32  data bus width; 32 or 64 only
//   ADDR_W   32  byte-address width
//   REG_W    5   destination register index width
// PORTS
//   clk          in   1         clock, rising edge
//   reset        in   1         asynchronous, active-low reset
//   req_valid    in   1         EX/MEM presents an access
//   req_ready    out  1         LSU can accept (state IDLE)
//   req_write    in   1         1 = store, 0 = load
//   req_size     in   2         00 byte, 01 half, 11 full DATA_W, 10 illegal
//   req_signed   in   1         load sign-extends when 1
//   req_addr     in   ADDR_W    byte address
//   req_wdata    in   DATA_W    store data, right-justified
//   req_rd       in   REG_W     load destination register
//   flush        in   1         kill the access in flight
//   busy         out  1         high in any state other than IDLE
//   mem_req      out  1         memory request
//   mem_gnt      in   1         memory accepted the request this cycle
//   mem_we       out  1         memory write
//   mem_addr     out  ADDR_W    aligned address (offset bits forced to 0)
//   mem_be       out  DATA_W/8  byte enables; MSB = byte offset 0
//   mem_wdata    out  DATA_W    lane-replicated store data
//   mem_rvalid   in   1         read data valid
//   mem_rdata    in   DATA_W    read data
//   rsp_valid    out  1         one-cycle completion pulse
//   rsp_is_load  out  1         completed access was a load
//   rsp_err      out  1         misaligned or illegal size; no memory access made
//   rsp_data     out  DATA_W    extended load data; 0 on stores and errors
//   rsp_rd       out  REG_W     captured req_rd
// BEHAVIOUR
//   - Reset: state IDLE. req_ready=1. All other outputs 0, including busy, mem_*, rsp_* and counters.
//     Reset mid-access aborts immediately, with no response. A late mem_rvalid arriving in IDLE is ignored.
//   - Accept on req_valid&&req_ready: capture all req_* fields, then go to REQ, or to ERR if the access is misaligned.
//   - Misaligned: half at an odd offset; full width at a nonzero offset; size 10 at any offset.
//   - FSM:
//     IDLE -accept-> REQ | ERR
//     REQ: mem_req=1 until mem_gnt, with addr/we/be/wdata held stable.
//       On gnt: a store goes to DONE, a load goes to WAIT. mem_rvalid is ignored in REQ.
//     WAIT: on mem_rvalid, register the extended data and go to DONE.
//     DONE: rsp_valid=1 for 1 cycle, then IDLE.
//     ERR: rsp_valid=1 and rsp_err=1 for 1 cycle, then IDLE.
//     DRAIN: waits for mem_rvalid, discards it, then IDLE with no rsp.
//   - Latency (mem_gnt in the first REQ cycle): accept T0, mem_req T1.
//     Store: rsp_valid T2. Load with rvalid at T2: rsp_valid T3. Error: rsp_valid T1.
//   - Lanes: offset o = addr[log2(DATA_W/8)-1:0]; byte o occupies bits [DATA_W-1-8o -: 8].
//     Byte store: data replicated into every lane, be one-hot.
//     Half store: data replicated, be pair.
//     Load: selected lane moved to the LSBs, then sign- or zero-extended to DATA_W.
//   - flush:
//     - in IDLE: no effect.
//     - in REQ before gnt: mem_req drops next cycle, go to IDLE, no rsp.
//     - in the same cycle as gnt: a store is still performed but its rsp is suppressed; a load goes to DRAIN.
//     - in WAIT: go to DRAIN, or straight to IDLE if mem_rvalid is in the same cycle.
//     - in DONE/ERR: the rsp pulse is suppressed.
//   - req_valid while busy is ignored; the upstream holds it.
// CONFIGURATION
//   LSU_PERF_CNT_EN defined: adds outputs perf_loads, perf_stores, perf_wait_cycles, each 32 bits, saturating at 2^32-1.
//     Loads/stores increment on a non-error, non-flushed rsp_valid.
//     perf_wait_cycles increments every cycle spent in REQ or WAIT.
//     All three reset to 0.
//   LSU_PERF_CNT_EN undefined: the ports still exist, tied to 0, and no counter flops are built.
// TESTING
//   - Load byte signed, addr 0x1001, rdata 0x12F45678, gnt immediate, rvalid next cycle
//     -> rsp_data 0xFFFFFFF4 at T3, mem_addr 0x1000, mem_be 0000.
//   - Store half, addr 0x2002, wdata 0x0000BEEF, gnt after 3 cycles
//     -> mem_be 0011, mem_wdata 0xBEEFBEEF held stable 3 cycles, rsp_valid 1 cycle after gnt.
//   - Load full width, addr 0x3002 -> rsp_err=1 at T1, mem_req never asserted, rsp_data 0.
//   - Load, flush asserted in WAIT, rvalid 2 cycles later
//     -> no rsp_valid, busy until the cycle after rvalid, then req_ready=1.
//   - Reset low while in REQ -> mem_req and busy 0 immediately; a later rvalid produces no rsp.
//   - DATA_W=64: load half unsigned at addr offset 6, rdata 0x0000_0000_0000_ABCD
//     -> rsp_data 0x000000000000ABCD.

Source files
------------

// File: rtl/pipeline_lsu.sv
// MEM-stage load/store unit: one outstanding req/gnt/rvalid access, big-endian lanes, optional LSU_PERF_CNT_EN counters.
// Latency: store rsp two cycles after accept, load rsp one cycle after rvalid, error rsp one cycle after accept.
// Backpressure: req_ready only in IDLE, mem_req held with stable payload until mem_gnt.
module pipeline_lsu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [REG_W-1:0]    req_rd,
  input  logic                flush,
  output logic                busy,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                rsp_valid,
  output logic                rsp_is_load,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [REG_W-1:0]    rsp_rd,
  output logic [31:0]         perf_loads,
  output logic [31:0]         perf_stores,
  output logic [31:0]         perf_wait_cycles
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_ERR, S_DRAIN} state_t;

  state_t            state, state_nxt;
  logic              accept, misaligned;
  logic [OFF_W-1:0]  req_off, off_q;
  logic              write_q, signed_q, err_q, rsp_q;
  logic [1:0]        size_q;
  logic [DATA_W-1:0] data_q, load_ext, rdata_sh, wdata_nxt;
  logic [BE_W-1:0]   be_nxt;

  assign accept  = req_valid && req_ready;
  assign req_off = req_addr[OFF_W-1:0];

  always_comb begin
    misaligned = 1'b1;
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_off[0];
      2'b11:   misaligned = |req_off;
      default: misaligned = 1'b1;
    endcase
  end

  // Store lanes: byte offset 0 is the MSB lane, so enables shift right from the top.
  always_comb begin
    be_nxt    = '0;
    wdata_nxt = '0;
    if (req_write) begin
      case (req_size)
        2'b00: begin
          be_nxt    = {1'b1, {(BE_W-1){1'b0}}} >> req_off;
          wdata_nxt = {BE_W{req_wdata[7:0]}};
        end
        2'b01: begin
          be_nxt    = {2'b11, {(BE_W-2){1'b0}}} >> req_off;
          wdata_nxt = {(BE_W/2){req_wdata[15:0]}};
        end
        2'b11: begin
          be_nxt    = '1;
          wdata_nxt = req_wdata;
        end
        default: ;
      endcase
    end
  end

  // Shifting left by the byte offset brings the addressed lane to the top bits.
  always_comb begin
    rdata_sh = mem_rdata << {off_q, 3'b000};
    case (size_q)
      2'b00:   load_ext = {{(DATA_W-8){signed_q & rdata_sh[DATA_W-1]}}, rdata_sh[DATA_W-1 -: 8]};
      2'b01:   load_ext = {{(DATA_W-16){signed_q & rdata_sh[DATA_W-1]}}, rdata_sh[DATA_W-1 -: 16]};
      default: load_ext = rdata_sh;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = misaligned ? S_ERR : S_REQ;
      S_REQ: begin
        // A flushed store that is granted has already been performed; only a flushed load must drain.
        if (flush)        state_nxt = (mem_gnt && !write_q) ? S_DRAIN : S_IDLE;
        else if (mem_gnt) state_nxt = write_q ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (flush)           state_nxt = mem_rvalid ? S_IDLE : S_DRAIN;
        else if (mem_rvalid) state_nxt = S_DONE;
      end
      S_DONE, S_ERR: state_nxt = S_IDLE;
      S_DRAIN: if (mem_rvalid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rsp_q     <= 1'b0;
      err_q     <= 1'b0;
      write_q   <= 1'b0;
      signed_q  <= 1'b0;
      size_q    <= '0;
      off_q     <= '0;
      data_q    <= '0;
      rsp_rd    <= '0;
    end else begin
      state     <= state_nxt;
      req_ready <= (state_nxt == S_IDLE);
      busy      <= (state_nxt != S_IDLE);
      mem_req   <= (state_nxt == S_REQ);
      mem_we    <= (state_nxt == S_REQ) && (accept ? req_write : write_q);
      rsp_q     <= (state_nxt == S_DONE) || (state_nxt == S_ERR);
      err_q     <= (state_nxt == S_ERR);
      if (accept) begin
        write_q   <= req_write;
        signed_q  <= req_signed;
        size_q    <= req_size;
        off_q     <= req_off;
        rsp_rd    <= req_rd;
        data_q    <= '0;
        mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        mem_be    <= misaligned ? '0 : be_nxt;
        mem_wdata <= misaligned ? '0 : wdata_nxt;
      end else if (state == S_WAIT && mem_rvalid && !flush) begin
        data_q <= load_ext;
      end
    end
  end

  // A flush during the response cycle cancels the pulse, so gating is combinational on flush.
  assign rsp_valid   = rsp_q && !flush;
  assign rsp_err     = rsp_valid && err_q;
  assign rsp_is_load = rsp_valid && !write_q;
  assign rsp_data    = data_q;

`ifdef LSU_PERF_CNT_EN
  logic [31:0] loads_q, stores_q, waits_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loads_q  <= '0;
      stores_q <= '0;
      waits_q  <= '0;
    end else begin
      if (rsp_valid && !err_q) begin
        if (write_q && stores_q != '1)       stores_q <= stores_q + 32'd1;
        else if (!write_q && loads_q != '1)  loads_q  <= loads_q + 32'd1;
      end
      if ((state == S_REQ || state == S_WAIT) && waits_q != '1) waits_q <= waits_q + 32'd1;
    end
  end

  assign perf_loads       = loads_q;
  assign perf_stores      = stores_q;
  assign perf_wait_cycles = waits_q;
`else
  assign perf_loads       = '0;
  assign perf_stores      = '0;
  assign perf_wait_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_lsu.sv
// Directed bench for pipeline_lsu: vector table on a 32-bit instance, hand sequences for flush/reset, 64-bit lanes.
module tb_pipeline_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        req_ready, busy, mem_req, mem_we, rsp_valid, rsp_is_load, rsp_err;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_addr, mem_wdata, rsp_data, perf_loads, perf_stores, perf_wait_cycles;
  logic [31:0] mem_rdata = '0;
  logic [3:0]  mem_be;
  logic [4:0]  rsp_rd;

  logic        w_req_valid = 1'b0, w_req_write = 1'b0, w_req_signed = 1'b0;
  logic [1:0]  w_req_size = 2'b00;
  logic [31:0] w_req_addr = '0;
  logic [63:0] w_req_wdata = '0;
  logic [4:0]  w_req_rd = '0;
  logic        w_req_ready, w_busy, w_mem_req, w_mem_we, w_rsp_valid, w_rsp_is_load, w_rsp_err;
  logic        w_mem_gnt = 1'b0, w_mem_rvalid = 1'b0;
  logic [31:0] w_mem_addr, w_perf_loads, w_perf_stores, w_perf_wait_cycles;
  logic [63:0] w_mem_wdata, w_rsp_data;
  logic [63:0] w_mem_rdata = '0;
  logic [7:0]  w_mem_be;
  logic [4:0]  w_rsp_rd;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_lsu #(.DATA_W(32), .ADDR_W(32), .REG_W(5)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .flush(flush), .busy(busy), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .rsp_valid(rsp_valid), .rsp_is_load(rsp_is_load), .rsp_err(rsp_err),
    .rsp_data(rsp_data), .rsp_rd(rsp_rd), .perf_loads(perf_loads), .perf_stores(perf_stores),
    .perf_wait_cycles(perf_wait_cycles)
  );

  pipeline_lsu #(.DATA_W(64), .ADDR_W(32), .REG_W(5)) dut64 (
    .clk(clk), .reset(reset), .req_valid(w_req_valid), .req_ready(w_req_ready), .req_write(w_req_write),
    .req_size(w_req_size), .req_signed(w_req_signed), .req_addr(w_req_addr), .req_wdata(w_req_wdata),
    .req_rd(w_req_rd), .flush(flush), .busy(w_busy), .mem_req(w_mem_req), .mem_gnt(w_mem_gnt),
    .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_be(w_mem_be), .mem_wdata(w_mem_wdata),
    .mem_rvalid(w_mem_rvalid), .mem_rdata(w_mem_rdata), .rsp_valid(w_rsp_valid),
    .rsp_is_load(w_rsp_is_load), .rsp_err(w_rsp_err), .rsp_data(w_rsp_data), .rsp_rd(w_rsp_rd),
    .perf_loads(w_perf_loads), .perf_stores(w_perf_stores), .perf_wait_cycles(w_perf_wait_cycles)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
    logic        err;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_data;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic do_access(input vec_t v, input logic [4:0] rd);
    @(negedge clk);
    chk("idle_ready", req_ready, 1);
    req_valid = 1'b1; req_write = v.wr; req_size = v.sz; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_rd = '0;
    if (v.err) begin
      chk("err_rsp_valid", rsp_valid, 1);
      chk("err_flag", rsp_err, 1);
      chk("err_data", rsp_data, 0);
      chk("err_no_mem_req", mem_req, 0);
      chk("err_rd", rsp_rd, rd);
      @(negedge clk);
      chk("err_pulse_end", rsp_valid, 0);
      chk("err_no_mem_req2", mem_req, 0);
      chk("err_ready_after", req_ready, 1);
    end else begin
      for (int c = 0; c <= v.dly; c++) begin
        chk("mem_req", mem_req, 1);
        chk("mem_we", mem_we, v.wr);
        chk("mem_addr", mem_addr, v.e_addr);
        chk("mem_be", mem_be, v.e_be);
        chk("mem_wdata", mem_wdata, v.e_wdata);
        chk("no_rsp_in_req", rsp_valid, 0);
        mem_gnt = (c == v.dly);
        @(negedge clk);
      end
      mem_gnt = 1'b0;
      if (!v.wr) begin
        chk("wait_no_rsp", rsp_valid, 0);
        chk("wait_busy", busy, 1);
        chk("wait_mem_req_low", mem_req, 0);
        mem_rvalid = 1'b1; mem_rdata = v.rdata;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = 32'h5A5A0F0F;
      end
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_err", rsp_err, 0);
      chk("rsp_is_load", rsp_is_load, !v.wr);
      chk("rsp_data", rsp_data, v.e_data);
      chk("rsp_rd", rsp_rd, rd);
      @(negedge clk);
      chk("rsp_pulse_end", rsp_valid, 0);
      chk("ready_after", req_ready, 1);
    end
  endtask

  // Leaves the caller at the negedge of the first cycle after acceptance.
  task automatic send_req(input logic wr, input logic [1:0] sz, input logic [31:0] addr, input logic [4:0] rd);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = 1'b0;
    req_addr = addr; req_wdata = 32'h11223344; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic w_access(input logic wr, input logic [1:0] sz, input logic sgn, input logic [31:0] addr,
                          input logic [63:0] wdata, input logic [63:0] rdata, input logic [7:0] e_be,
                          input logic [63:0] e_wdata, input logic [63:0] e_data);
    @(negedge clk);
    w_req_valid = 1'b1; w_req_write = wr; w_req_size = sz; w_req_signed = sgn;
    w_req_addr = addr; w_req_wdata = wdata; w_req_rd = 5'd7;
    @(negedge clk);
    w_req_valid = 1'b0;
    chk("w64_mem_req", w_mem_req, 1);
    chk("w64_mem_addr", w_mem_addr, {addr[31:3], 3'b000});
    chk("w64_mem_be", w_mem_be, e_be);
    chk("w64_mem_wdata", w_mem_wdata, e_wdata);
    w_mem_gnt = 1'b1;
    @(negedge clk);
    w_mem_gnt = 1'b0;
    if (!wr) begin
      w_mem_rvalid = 1'b1; w_mem_rdata = rdata;
      @(negedge clk);
      w_mem_rvalid = 1'b0; w_mem_rdata = '0;
    end
    chk("w64_rsp_valid", w_rsp_valid, 1);
    chk("w64_rsp_data", w_rsp_data, e_data);
    chk("w64_rsp_rd", w_rsp_rd, 5'd7);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          wr    sz     sgn   addr          wdata         rdata         dly err   e_addr        e_be     e_wdata       e_data
    vt[0]  = '{1'b0, 2'b00, 1'b1, 32'h00001001, 32'h0,        32'h12F45678, 0, 1'b0, 32'h00001000, 4'b0000, 32'h0,        32'hFFFFFFF4};
    vt[1]  = '{1'b1, 2'b01, 1'b0, 32'h00002002, 32'h0000BEEF, 32'h0,        3, 1'b0, 32'h00002000, 4'b0011, 32'hBEEFBEEF, 32'h0};
    vt[2]  = '{1'b0, 2'b11, 1'b0, 32'h00003002, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
    vt[3]  = '{1'b0, 2'b00, 1'b0, 32'h00001003, 32'h0,        32'h12F456F8, 0, 1'b0, 32'h00001000, 4'b0000, 32'h0,        32'h000000F8};
    vt[4]  = '{1'b0, 2'b01, 1'b1, 32'h00004000, 32'h0,        32'h80011234, 0, 1'b0, 32'h00004000, 4'b0000, 32'h0,        32'hFFFF8001};
    vt[5]  = '{1'b0, 2'b01, 1'b0, 32'h00004002, 32'h0,        32'h80011234, 0, 1'b0, 32'h00004000, 4'b0000, 32'h0,        32'h00001234};
    vt[6]  = '{1'b0, 2'b01, 1'b1, 32'h00004002, 32'h0,        32'h12349ABC, 0, 1'b0, 32'h00004000, 4'b0000, 32'h0,        32'hFFFF9ABC};
    vt[7]  = '{1'b0, 2'b11, 1'b1, 32'h00005004, 32'h0,        32'hDEADBEEF, 2, 1'b0, 32'h00005004, 4'b0000, 32'h0,        32'hDEADBEEF};
    vt[8]  = '{1'b1, 2'b00, 1'b0, 32'h00006001, 32'h123456A5, 32'h0,        0, 1'b0, 32'h00006000, 4'b0100, 32'hA5A5A5A5, 32'h0};
    vt[9]  = '{1'b1, 2'b00, 1'b0, 32'h00006003, 32'h0000005A, 32'h0,        0, 1'b0, 32'h00006000, 4'b0001, 32'h5A5A5A5A, 32'h0};
    vt[10] = '{1'b1, 2'b11, 1'b0, 32'h00007000, 32'hCAFEF00D, 32'h0,        1, 1'b0, 32'h00007000, 4'b1111, 32'hCAFEF00D, 32'h0};
    vt[11] = '{1'b1, 2'b01, 1'b0, 32'h00007001, 32'h00001234, 32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
    vt[12] = '{1'b0, 2'b10, 1'b0, 32'h00008000, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
    vt[13] = '{1'b0, 2'b01, 1'b1, 32'h00008003, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
    vt[14] = '{1'b1, 2'b11, 1'b0, 32'h00007002, 32'h55667788, 32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
    vt[15] = '{1'b0, 2'b00, 1'b0, 32'h00001000, 32'h0,        32'h12F45678, 0, 1'b0, 32'h00001000, 4'b0000, 32'h0,        32'h00000012};

    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_perf_loads", perf_loads, 0);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) do_access(vt[i], 5'(i + 1));

`ifdef LSU_PERF_CNT_EN
    chk("perf_loads", perf_loads, 7);
    chk("perf_stores", perf_stores, 4);
    chk("perf_wait_cycles", perf_wait_cycles, 24);
`else
    chk("perf_loads_tied", perf_loads, 0);
    chk("perf_stores_tied", perf_stores, 0);
    chk("perf_wait_tied", perf_wait_cycles, 0);
`endif

    // flush in REQ before gnt
    send_req(1'b0, 2'b11, 32'h100, 5'd1);
    chk("fb_mem_req", mem_req, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fb_mem_req_drop", mem_req, 0);
    chk("fb_busy", busy, 0);
    chk("fb_ready", req_ready, 1);
    chk("fb_no_rsp", rsp_valid, 0);

    // flush with gnt on a store: performed, no response
    send_req(1'b1, 2'b11, 32'h200, 5'd2);
    chk("fgs_we", mem_we, 1);
    mem_gnt = 1'b1; flush = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; flush = 1'b0;
    chk("fgs_mem_req", mem_req, 0);
    chk("fgs_busy", busy, 0);
    chk("fgs_no_rsp", rsp_valid, 0);

    // flush with gnt on a load: drain the read
    send_req(1'b0, 2'b11, 32'h300, 5'd3);
    mem_gnt = 1'b1; flush = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; flush = 1'b0;
    chk("fgl_busy", busy, 1);
    chk("fgl_no_rsp", rsp_valid, 0);
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("fgl_idle", busy, 0);
    chk("fgl_no_rsp2", rsp_valid, 0);

    // flush in WAIT, rvalid two cycles later
    send_req(1'b0, 2'b11, 32'h400, 5'd4);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fw_busy1", busy, 1);
    chk("fw_no_rsp1", rsp_valid, 0);
    @(negedge clk);
    chk("fw_busy2", busy, 1);
    mem_rvalid = 1'b1; mem_rdata = 32'hAAAA5555;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("fw_no_rsp2", rsp_valid, 0);
    chk("fw_busy_end", busy, 0);
    chk("fw_ready", req_ready, 1);

    // flush in WAIT together with rvalid
    send_req(1'b0, 2'b11, 32'h500, 5'd5);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; flush = 1'b1; mem_rvalid = 1'b1;
    @(negedge clk);
    flush = 1'b0; mem_rvalid = 1'b0;
    chk("fwr_busy", busy, 0);
    chk("fwr_no_rsp", rsp_valid, 0);

    // flush during DONE and ERR suppresses the pulse
    send_req(1'b1, 2'b00, 32'h600, 5'd6);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("fd_rsp_before", rsp_valid, 1);
    flush = 1'b1;
    #1;
    chk("fd_rsp_suppressed", rsp_valid, 0);
    @(negedge clk);
    flush = 1'b0;
    chk("fd_ready", req_ready, 1);
    send_req(1'b0, 2'b10, 32'h700, 5'd7);
    chk("fe_rsp_before", rsp_valid, 1);
    flush = 1'b1;
    #1;
    chk("fe_rsp_suppressed", rsp_valid, 0);
    chk("fe_err_suppressed", rsp_err, 0);
    @(negedge clk);
    flush = 1'b0;

    // flush in IDLE has no effect on acceptance
    flush = 1'b1;
    send_req(1'b1, 2'b11, 32'h800, 5'd8);
    flush = 1'b0;
    chk("fi_accepted", mem_req, 1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("fi_rsp", rsp_valid, 1);

    // reset while in REQ aborts; late rvalid is ignored
    send_req(1'b0, 2'b11, 32'h900, 5'd9);
    chk("rr_mem_req", mem_req, 1);
    reset = 1'b0;
    #1;
    chk("rr_mem_req_low", mem_req, 0);
    chk("rr_busy_low", busy, 0);
    chk("rr_ready", req_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("rr_no_rsp", rsp_valid, 0);
    chk("rr_still_idle", busy, 0);

    // 64-bit lanes
    w_access(1'b0, 2'b01, 1'b0, 32'h00001006, 64'h0, 64'h000000000000ABCD, 8'h00, 64'h0, 64'h000000000000ABCD);
    w_access(1'b0, 2'b00, 1'b1, 32'h00002000, 64'h0, 64'h80FF00FF00FF00FF, 8'h00, 64'h0, 64'hFFFFFFFFFFFFFF80);
    w_access(1'b1, 2'b00, 1'b0, 32'h00003005, 64'h77, 64'h0, 8'b00000100, 64'h7777777777777777, 64'h0);
    w_access(1'b0, 2'b01, 1'b1, 32'h00004002, 64'h0, 64'h1234F00D56789ABC, 8'h00, 64'h0, 64'hFFFFFFFFFFFFF00D);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
